// File: rtl/ram_pkg.sv
// Shared types and helpers for the masked RAM bank: clear FSM states and lane
// arithmetic used by both the array write path and the read bypass.
package ram_pkg;

  localparam int unsigned MAX_WIDTH     = 256;
  localparam int unsigned MAX_MASK_BITS = 32;

  typedef enum logic {IDLE, CLEAR} clear_state_t;

  typedef logic [MAX_WIDTH-1:0]     word_t;
  typedef logic [MAX_MASK_BITS-1:0] lane_mask_t;

  function automatic int unsigned lane_width(int unsigned width, int unsigned mask_bits);
    return width / mask_bits;
  endfunction

  // Words are zero-extended to MAX_WIDTH so one function serves every instance width.
  function automatic word_t merge_lanes(word_t old_word, word_t new_word, lane_mask_t mask,
                                        int unsigned lane);
    word_t lane_ones;
    word_t bit_mask;
    lane_ones = (word_t'(1) << lane) - word_t'(1);
    bit_mask  = '0;
    for (int unsigned i = 0; i < MAX_MASK_BITS; i++) begin
      if (mask[i]) bit_mask = bit_mask | (lane_ones << (i * lane));
    end
    return (old_word & ~bit_mask) | (new_word & bit_mask);
  endfunction

endpackage

// File: rtl/ram_clear_sequencer.sv
// Clear sequencer: walks every address once, writing zero, and holds busy
// for exactly DEPTH cycles. Requests arriving mid-clear are ignored.
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_BITS      = 4,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 clear_we,
  output logic [ADDR_BITS-1:0] clear_addr,
  output logic                 busy
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH - 1);

  clear_state_t         state;
  logic [ADDR_BITS-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= CLEAR_ON_RESET ? CLEAR : IDLE;
      count <= '0;
      busy  <= CLEAR_ON_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            state <= CLEAR;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        CLEAR: begin
          if (count == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            count <= '0;
          end else begin
            count <= count + ADDR_BITS'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          count <= '0;
        end
      endcase
    end
  end

  assign clear_we   = (state == CLEAR);
  assign clear_addr = count;

endmodule

// File: rtl/masked_ram_bank.sv
// Lane-masked RAM with one write and one read port, selectable read latency
// (0/1/2), same-cycle write-to-read bypass and a hardware clear sequencer.
module masked_ram_bank
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned ADDR_BITS      = 4,
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned MASK_BITS      = 4,
  parameter int unsigned READ_LATENCY   = 1,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [MASK_BITS-1:0] write_mask,
  input  logic [ADDR_BITS-1:0] write_addr,
  input  logic [WIDTH-1:0]     write_data,
  input  logic                 read_en,
  input  logic [ADDR_BITS-1:0] read_addr,
  output logic [WIDTH-1:0]     read_data,
  output logic                 read_valid,
  input  logic                 clear_req,
  output logic                 busy
);

  localparam int unsigned LANE  = lane_width(WIDTH, MASK_BITS);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 clear_we;
  logic [ADDR_BITS-1:0] clear_addr;
  logic                 write_ok;
  logic                 read_ok;
  logic                 read_in_range;
  logic [WIDTH-1:0]     read_word;
  logic [WIDTH-1:0]     write_word;

  ram_clear_sequencer #(
    .DEPTH          (DEPTH),
    .ADDR_BITS      (ADDR_BITS),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .busy       (busy)
  );

  assign write_ok      = write_en & ~busy & (32'(write_addr) < DEPTH);
  assign read_ok       = read_en & ~busy;
  assign read_in_range = 32'(read_addr) < DEPTH;
  assign read_word     = read_in_range ? mem[read_addr[IDX_W-1:0]] : '0;
  assign write_word    = WIDTH'(merge_lanes(word_t'(mem[write_addr[IDX_W-1:0]]),
                                            word_t'(write_data),
                                            lane_mask_t'(write_mask), LANE));

  // busy gates user writes, so the clear port simply takes priority.
  always_ff @(posedge clock) begin
    if (clear_we) begin
      mem[clear_addr[IDX_W-1:0]] <= '0;
    end else if (write_ok) begin
      mem[write_addr[IDX_W-1:0]] <= write_word;
    end
  end

  if (READ_LATENCY == 0) begin : g_lat0
    logic [WIDTH-1:0] held;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        held <= '0;
      end else if (read_ok) begin
        held <= read_word;
      end
    end

    assign read_data  = read_ok ? read_word : held;
    assign read_valid = read_ok;
  end else begin : g_lat_reg
    logic             bypass_hit;
    logic [WIDTH-1:0] bypass_word;
    logic             valid_1;
    logic [WIDTH-1:0] data_1;

    // A hit implies write_word was merged from this same old word.
    assign bypass_hit  = write_ok && (write_addr == read_addr);
    assign bypass_word = bypass_hit ? write_word : read_word;

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        valid_1 <= 1'b0;
        data_1  <= '0;
      end else begin
        valid_1 <= read_ok;
        if (read_ok) data_1 <= bypass_word;
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      assign read_valid = valid_1;
      assign read_data  = data_1;
    end else begin : g_lat2
      logic             valid_2;
      logic [WIDTH-1:0] data_2;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          valid_2 <= 1'b0;
          data_2  <= '0;
        end else begin
          valid_2 <= valid_1;
          if (valid_1) data_2 <= data_1;
        end
      end

      assign read_valid = valid_2;
      assign read_data  = data_2;
    end
  end

endmodule

// File: doc/masked_ram_bank.md
# masked_ram_bank

Parametrised successor to the single-lane RAM primitive used by lowered FIRRTL memories: per-lane byte-style write masking, selectable read latency (0/1/2), same-cycle write-to-read bypass, and a hardware clear sequencer that zeroes the array after reset or on request. It instantiates in place of the flat RAM primitive wherever the lowering emits a masked or sync-read memory. Callers see one write port and one read port, both on `clock`.

## Interface
- `DEPTH`, 16: number of words; 1..2^ADDR_BITS.
- `ADDR_BITS`, 4: address width.
- `WIDTH`, 32: word width; must be divisible by MASK_BITS.
- `MASK_BITS`, 4: number of write lanes; lane width LANE = WIDTH/MASK_BITS.
- `READ_LATENCY`, 1: 0 = combinational, 1 or 2 = registered stages.
- `CLEAR_ON_RESET`, 1: 1 = run the clear sequence automatically after reset release.

Ports:
- `clock`  in  1  sole clock; all state is on its rising edge.
- `reset`  in  1  asynchronous, active-low.
- `write_en`  in  1  write request.
- `write_mask`  in  MASK_BITS  bit i enables lane i (bits [i*LANE +: LANE]).
- `write_addr`  in  ADDR_BITS  write address.
- `write_data`  in  WIDTH  write data.
- `read_en`  in  1  read request.
- `read_addr`  in  ADDR_BITS  read address.
- `read_data`  out  WIDTH  read result.
- `read_valid`  out  1  read_data holds an accepted read result.
- `clear_req`  in  1  single-cycle pulse; starts a clear when IDLE.
- `busy`  out  1  clear in progress; all requests are ignored while high.

## Operation
- FSM states: IDLE and CLEAR. Reset enters CLEAR when CLEAR_ON_RESET=1, otherwise IDLE. IDLE→CLEAR on clear_req. CLEAR→IDLE after the cycle that writes address DEPTH-1.
- CLEAR: a counter runs 0..DEPTH-1 and writes all-zero to one word per cycle, for DEPTH cycles exactly. busy=1 for the whole of CLEAR.
- clear_req while in CLEAR: ignored. It neither restarts nor extends the clear.
- Write: accepted when write_en & ~busy & write_addr<DEPTH. Only lanes whose mask bit is set are updated. A write with an all-zero mask is a no-op. A write to an out-of-range address is dropped.
- Read: accepted when read_en & ~busy. An out-of-range read_addr returns 0.
- Bypass (READ_LATENCY≥1): when a read and a write are accepted to the same address in the same cycle, masked lanes return the new data and unmasked lanes return the old data.
- READ_LATENCY=0: read_data is combinational from the array contents before the clock edge. The same-cycle write is not visible.
- Between accepted reads, read_data holds its last value (stages are not cleared).

## Timing
- Reset values: read_data=0, read_valid=0, busy=1 if CLEAR_ON_RESET else 0, FSM state as above, clear counter=0.
- Array contents are not reset by `reset`. Only CLEAR zeroes them.
- Latency 0: read_valid = read_en & ~busy, in the same cycle.
- Latency 1: read_valid pulses 1 cycle after acceptance. Latency 2: 2 cycles after. Fully pipelined, one read per cycle.
- Clear after reset release: busy falls on cycle DEPTH. The first accepted request is in cycle DEPTH.
- Reset asserted mid-clear: the counter returns to 0. When CLEAR_ON_RESET=1 a full clear restarts after release.
- Reset asserted mid-read-pipeline: in-flight results are lost and read_valid=0.
- A read accepted in the cycle before clear_req still completes with pre-clear data.

## Structure
- Shared package `ram_pkg`:
  - FSM state enum (IDLE, CLEAR).
  - Lane-width function `lane_width(WIDTH, MASK_BITS)`.
  - Lane merge function `merge_lanes(old, new, mask)`, used by both the array write and the bypass path.
- Sub-module `ram_clear_sequencer`: FSM, counter and busy. It outputs clear_we, clear_addr and busy. The top level muxes the clear writes over the user write port.
- The array, the read stages and the bypass compare stay in `masked_ram_bank`, with generate branches per READ_LATENCY.

## Test plan
- Clear after reset: DEPTH=16, CLEAR_ON_RESET=1, release reset. Required: busy=1 for exactly 16 cycles, then reads of addresses 0..15 all return 0.
- Masked write: WIDTH=32, MASK_BITS=4. Write 0xFFFFFFFF to address 3, then write 0x12345678 with mask 4'b0101. Required: READ_LATENCY=1 read returns 0xFF34FF78 one cycle after acceptance.
- Bypass: in the same cycle, read address 5 (holding 0xAAAAAAAA) and write 0x11223344 with mask 4'b1100 to address 5. Required: 0x1122AAAA (latency 1). With READ_LATENCY=0, 0xAAAAAAAA in the same cycle.
- Busy gating: pulse clear_req, and assert write_en to address 2 during CLEAR. Required: the write is dropped, read_valid stays 0, address 2 reads 0 after busy falls, and a second clear_req during CLEAR does not extend busy past 16 cycles.
- Boundaries: DEPTH=12, ADDR_BITS=4. Write to address 13, then read address 13, then read address 11. Required: address 13 returns 0 and the array is unchanged; address 11 returns its value, with latency-2 read_valid exactly 2 cycles after acceptance.
- Reset mid-clear: assert reset at clear cycle 7 and release. Required: busy=1 for a full 16 cycles again, and read_valid=0 throughout.
